// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl: zero-fills a dual-port SRAM, then turns write/read streams into SRAM strobes with a 2-entry response buffer
module sram_stream_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  init_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_aa,
  output logic [DATA_WIDTH-1:0] sram_da,
  output logic                  sram_ceba,
  output logic                  sram_weba,
  output logic [ADDR_WIDTH-1:0] sram_ab,
  output logic                  sram_cebb,
  output logic                  sram_webb,
  input  logic [DATA_WIDTH-1:0] sram_qb
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {INIT, RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wp_q, wp_d, rp_q, rp_d;
  logic [1:0]            count_q, count_d;
  logic                  run, wr_fire, rd_fire, push, pop, flush;
  // State, init counter and response buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
  // Leave INIT once the last address is written; clear restarts the fill
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == (ADDR_WIDTH+1)'(DEPTH - 1)) state_d = RUN;
    if (state_q == RUN && clear) state_d = INIT;
  end
  // SRAM strobes and handshakes; INIT strobes are held off while reset is asserted
  always_comb begin
    run          = state_q == RUN;
    init_done    = run;
    wr_ready     = run;
    rd_req_ready = run & ((count_q != 2'd2) | rd_rsp_ready);
    wr_fire      = run & wr_valid;
    rd_fire      = rd_req_valid & rd_req_ready;
    sram_ceba    = (~run & rst_n) ? 1'b0 : ~wr_fire;
    sram_weba    = sram_ceba;
    sram_aa      = run ? wr_addr : cnt_q[ADDR_WIDTH-1:0];
    sram_da      = run ? wr_data : '0;
    sram_cebb    = ~rd_fire;
    sram_webb    = 1'b1;
    sram_ab      = rd_req_addr;
    rd_rsp_valid = count_q != 2'd0;
    rd_rsp_data  = mem_q[rp_q];
  end
  // Fill counter and response FIFO; clear drops anything buffered, including this cycle's read
  always_comb begin
    flush   = run & clear;
    push    = rd_fire & ~clear;
    pop     = rd_rsp_valid & rd_rsp_ready;
    cnt_d   = run ? (clear ? '0 : cnt_q) : cnt_q + 1'b1;
    mem_d   = mem_q;
    if (push) mem_d[wp_q] = sram_qb;
    wp_d    = flush ? 1'b0 : wp_q ^ push;
    rp_d    = flush ? 1'b0 : rp_q ^ pop;
    count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
  end
endmodule

// File: tb/tb_sram_stream_ctrl.sv
// tb_sram_stream_ctrl: directed stimulus with a transaction-level memory/queue model checked every cycle
module tb_sram_stream_ctrl;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int DEPTH = 2 ** AW;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic init_done, wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0, rd_req_addr = '0, sram_aa, sram_ab;
  logic [DW-1:0] wr_data = '0, rd_rsp_data, sram_da, sram_qb;
  logic rd_req_valid = 1'b0, rd_req_ready, rd_rsp_valid, rd_rsp_ready = 1'b1;
  logic sram_ceba, sram_weba, sram_cebb, sram_webb;
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] q [$];
  int init_left = DEPTH;
  int pass_cnt = 0, chk_cnt = 0;

  sram_stream_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .sram_aa(sram_aa), .sram_da(sram_da), .sram_ceba(sram_ceba), .sram_weba(sram_weba),
    .sram_ab(sram_ab), .sram_cebb(sram_cebb), .sram_webb(sram_webb), .sram_qb(sram_qb)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) sram[i] = 32'hDEAD0000 + i;
  always @(posedge clk) if (!sram_ceba && !sram_weba) sram[sram_aa] <= sram_da;
  assign sram_qb = sram_cebb ? '0 : sram[sram_ab];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  function automatic bit exp_rd_ready();
    return init_left == 0 && (q.size() < 2 || rd_rsp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_left = DEPTH;
      q.delete();
    end else if (init_left > 0) begin
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      automatic bit rf = rd_req_valid && exp_rd_ready();
      automatic logic [DW-1:0] old = ref_mem[rd_req_addr];
      if (q.size() > 0 && rd_rsp_ready) void'(q.pop_front());
      if (wr_valid) ref_mem[wr_addr] = wr_data;
      if (clear) begin
        q.delete();
        init_left = DEPTH;
      end else if (rf) q.push_back(old);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_init_done", init_done, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_req_ready", rd_req_ready, 0);
      chk("rst_rd_rsp_valid", rd_rsp_valid, 0);
      chk("rst_rd_rsp_data", rd_rsp_data, 0);
      chk("rst_ceba", sram_ceba, 1);
      chk("rst_weba", sram_weba, 1);
      chk("rst_cebb", sram_cebb, 1);
      chk("rst_webb", sram_webb, 1);
    end else begin
      automatic bit run = init_left == 0;
      automatic bit ecebb = !(rd_req_valid && exp_rd_ready());
      chk("init_done", init_done, run);
      chk("wr_ready", wr_ready, run);
      chk("rd_req_ready", rd_req_ready, exp_rd_ready());
      chk("rd_rsp_valid", rd_rsp_valid, q.size() != 0);
      if (q.size() != 0) chk("rd_rsp_data", rd_rsp_data, q[0]);
      chk("sram_ceba", sram_ceba, run ? !wr_valid : 1'b0);
      chk("sram_weba", sram_weba, run ? !wr_valid : 1'b0);
      if (!run) begin
        chk("sram_aa_init", sram_aa, DEPTH - init_left);
        chk("sram_da_init", sram_da, 0);
      end else if (wr_valid) begin
        chk("sram_aa", sram_aa, wr_addr);
        chk("sram_da", sram_da, wr_data);
      end
      chk("sram_cebb", sram_cebb, ecebb);
      chk("sram_webb", sram_webb, 1);
      if (!ecebb) chk("sram_ab", sram_ab, rd_req_addr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_req_valid = 1'b1; rd_req_addr = a;
    cyc();
    rd_req_valid = 1'b0;
  endtask

  task automatic init_seq();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("init_aa", sram_aa, i);
      chk("init_busy", init_done, 0);
      chk("init_rsp_valid", rd_rsp_valid, 0);
      cyc();
    end
    @(negedge clk);
    chk("init_done_rise", init_done, 1);
  endtask

  task automatic rsp_is(input string n, input logic [DW-1:0] d);
    @(negedge clk);
    chk({n, "_valid"}, rd_rsp_valid, 1);
    chk({n, "_data"}, rd_rsp_data, d);
  endtask

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    init_seq();
    cyc();
    rd(5);
    rsp_is("t1_rd5", 0);
    cyc();
    wr(3, 32'hA5);
    rd(3);
    rsp_is("t2_rd3", 32'hA5);
    cyc();
    wr_valid = 1'b1; wr_addr = 2; wr_data = 32'h11;
    rd_req_valid = 1'b1; rd_req_addr = 2;
    cyc();
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    rsp_is("t3_old", 0);
    cyc();
    rd(2);
    rsp_is("t3_new", 32'h11);
    cyc();
    wr(1, 32'hB1);
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 1;
    cyc();
    rd_req_addr = 2;
    cyc();
    rd_req_addr = 3;
    @(negedge clk);
    chk("t4_full_ready", rd_req_ready, 0);
    cyc();
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_ready", rd_req_ready, 1);
    chk("t4_rsp1", rd_rsp_data, 32'hB1);
    cyc();
    rd_req_valid = 1'b0;
    rsp_is("t4_rsp2", 32'h11);
    cyc();
    rsp_is("t4_rsp3", 32'hA5);
    cyc();
    @(negedge clk);
    chk("t4_empty", rd_rsp_valid, 0);
    cyc();
    rd_rsp_ready = 1'b0;
    rd(1);
    rd(2);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    init_seq();
    rd_rsp_ready = 1'b1;
    cyc();
    rd(3);
    rsp_is("t5_zero3", 0);
    cyc();
    rd(1);
    rsp_is("t5_zero1", 0);
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_async_done", init_done, 0);
    chk("t6_async_ceba", sram_ceba, 1);
    chk("t6_async_weba", sram_weba, 1);
    chk("t6_async_rdy", rd_req_ready, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    init_seq();
    cyc();
    wr(6, 32'h66);
    rd(6);
    rsp_is("t6_after", 32'h66);
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
